// File: rtl/testimage_seq.sv
// testimage_seq: frame sequencer driving a test image generator through TESTON/TESTEND
module testimage_seq #(
    parameter int FRAME_W = 8,
    parameter int MIN_GAP = 4,
    parameter int ARM_CYC = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               ABORT,
    input  logic [FRAME_W-1:0] FRAME_NUM,
    input  logic [15:0]        GAP_CYCLES,
    input  logic [31:0]        TIMEOUT,
    input  logic               TESTEND,
    output logic               TESTON,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [FRAME_W-1:0] FRAME_CNT
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, GAP} state_t;
    state_t             state;
    logic [FRAME_W-1:0] num_q;
    logic [15:0]        gap_q;
    logic [31:0]        tmo_q;
    logic [31:0]        wdog;
    logic [15:0]        cnt;
    logic [15:0]        gap_len;
    logic [FRAME_W-1:0] cnt_nxt;
    logic               wd_hit;
    logic               last;
    // gap length clamp, frame count increment, watchdog hit and last-frame detect
    always_comb begin
        gap_len = (gap_q < 16'(MIN_GAP)) ? 16'(MIN_GAP) : gap_q;
        cnt_nxt = FRAME_CNT + 1'b1;
        wd_hit  = (tmo_q != 32'd0) && (wdog + 32'd1 == tmo_q);
        last    = (num_q != '0) && (cnt_nxt == num_q);
    end
    // sequencer FSM with registered outputs; ABORT outranks TESTEND, watchdog and START
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            TESTON    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            FRAME_CNT <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            wdog      <= '0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (START && !ABORT) begin
                state     <= ARM;
                TESTON    <= 1'b1;
                BUSY      <= 1'b1;
                DONE      <= 1'b0;
                ERR       <= 1'b0;
                FRAME_CNT <= '0;
                num_q     <= FRAME_NUM;
                gap_q     <= GAP_CYCLES;
                tmo_q     <= TIMEOUT;
                wdog      <= '0;
                cnt       <= '0;
            end
        end else if (ABORT) begin
            state  <= IDLE;
            TESTON <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    wdog <= wdog + 32'd1;
                    if (wd_hit) begin
                        state  <= IDLE;
                        TESTON <= 1'b0;
                        BUSY   <= 1'b0;
                        ERR    <= 1'b1;
                    end else if (cnt == 16'(ARM_CYC - 1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RUN: begin
                    wdog <= wdog + 32'd1;
                    if (TESTEND) begin
                        FRAME_CNT <= cnt_nxt;
                        TESTON    <= 1'b0;
                        cnt       <= '0;
                        state     <= last ? IDLE : GAP;
                        BUSY      <= !last;
                        DONE      <= last;
                    end else if (wd_hit) begin
                        state  <= IDLE;
                        TESTON <= 1'b0;
                        BUSY   <= 1'b0;
                        ERR    <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == gap_len - 16'd1) begin
                        state  <= ARM;
                        TESTON <= 1'b1;
                        cnt    <= '0;
                        wdog   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_testimage_seq.sv
// tb_testimage_seq: directed checks of the frame sequencer against a simple generator model
module tb_testimage_seq;
    logic        CLK = 1'b0;
    logic        RST, START, ABORT, TESTEND;
    logic [7:0]  FRAME_NUM;
    logic [15:0] GAP_CYCLES;
    logic [31:0] TIMEOUT;
    logic        TESTON, BUSY, DONE, ERR;
    logic [7:0]  FRAME_CNT;
    logic        teston2, busy2, done2, err2;
    logic [1:0]  frame_cnt2;
    logic        gen_en = 1'b0;
    logic        man_te = 1'b0;
    logic        stale = 1'b0;
    int          hi_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n;

    testimage_seq dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .FRAME_NUM(FRAME_NUM),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .TESTEND(TESTEND),
        .TESTON(TESTON), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .FRAME_CNT(FRAME_CNT)
    );

    testimage_seq #(.FRAME_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .FRAME_NUM(FRAME_NUM[1:0]),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .TESTEND(TESTEND),
        .TESTON(teston2), .BUSY(busy2), .DONE(done2), .ERR(err2), .FRAME_CNT(frame_cnt2)
    );

    always #5 CLK = ~CLK;

    // generator model: frame of 8 TESTON-high cycles, TESTEND stays high into the next frame's 5th cycle
    always @(negedge CLK) begin
        hi_cnt = TESTON ? hi_cnt + 1 : 0;
        if (hi_cnt >= 8) stale = 1'b1;
        else if (hi_cnt == 5) stale = 1'b0;
    end

    assign TESTEND = gen_en ? stale : man_te;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (TESTON === lvl && len < 1000) begin
            len++;
            @(negedge CLK);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; START = 1'b1; ABORT = 1'b1; man_te = 1'b1;
        FRAME_NUM = 8'd3; GAP_CYCLES = 16'd7; TIMEOUT = 32'd9;
        repeat (3) @(negedge CLK);
        chk("rst_teston", TESTON, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_cnt", FRAME_CNT, 0);
        RST = 1'b0; START = 1'b0; ABORT = 1'b0; man_te = 1'b0;
        @(negedge CLK);
        chk("idle_teston", TESTON, 0);
        // two frames, gap 10; config changes after START must not matter
        gen_en = 1'b1; FRAME_NUM = 8'd2; GAP_CYCLES = 16'd10; TIMEOUT = 32'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; FRAME_NUM = 8'd1; GAP_CYCLES = 16'd0;
        chk("start_latency", TESTON, 1);
        chk("start_busy", BUSY, 1);
        run_len(1'b1, n); chk("f2_hi1", n, 8);
        run_len(1'b0, n); chk("f2_gap", n, 10);
        run_len(1'b1, n); chk("f2_hi2", n, 8);
        chk("f2_cnt", FRAME_CNT, 2);
        chk("f2_done", DONE, 1);
        chk("f2_busy", BUSY, 0);
        // gap 0 clamps to 4; stale TESTEND during ARM ignored
        FRAME_NUM = 8'd3; GAP_CYCLES = 16'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("f3_done_clr", DONE, 0);
        run_len(1'b1, n); chk("f3_hi1", n, 8);
        run_len(1'b0, n); chk("f3_gap1", n, 4);
        run_len(1'b1, n); chk("f3_hi2", n, 8);
        run_len(1'b0, n); chk("f3_gap2", n, 4);
        run_len(1'b1, n); chk("f3_hi3", n, 8);
        chk("f3_cnt", FRAME_CNT, 3);
        chk("f3_done", DONE, 1);
        // watchdog expiry with TESTEND never asserted
        gen_en = 1'b0; man_te = 1'b0; FRAME_NUM = 8'd1; TIMEOUT = 32'd100; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        run_len(1'b1, n); chk("wd_len", n, 100);
        chk("wd_err", ERR, 1);
        chk("wd_cnt", FRAME_CNT, 0);
        chk("wd_done", DONE, 0);
        chk("wd_busy", BUSY, 0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_abort_err", ERR, 1);
        chk("idle_abort_teston", TESTON, 0);
        // TESTEND coincident with watchdog expiry: frame counted
        TIMEOUT = 32'd6; FRAME_NUM = 8'd1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        man_te = 1'b1;
        @(negedge CLK);
        man_te = 1'b0;
        chk("tie_cnt", FRAME_CNT, 1);
        chk("tie_done", DONE, 1);
        chk("tie_err", ERR, 0);
        // continuous mode, START while busy ignored, ABORT in third frame RUN
        gen_en = 1'b1; FRAME_NUM = 8'd0; GAP_CYCLES = 16'd5; TIMEOUT = 32'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("cont_err_clr", ERR, 0);
        run_len(1'b1, n); chk("cont_hi1", n, 8);
        run_len(1'b0, n); chk("cont_gap1", n, 5);
        run_len(1'b1, n); chk("cont_hi2", n, 8);
        run_len(1'b0, n); chk("cont_gap2", n, 5);
        START = 1'b1; FRAME_NUM = 8'd1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("busy_run3", BUSY, 1);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_teston", TESTON, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_cnt", FRAME_CNT, 2);
        chk("abort_done", DONE, 0);
        // ABORT and TESTEND in the same RUN cycle
        gen_en = 1'b0; FRAME_NUM = 8'd0; GAP_CYCLES = 16'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        man_te = 1'b1;
        @(negedge CLK);
        man_te = 1'b0;
        chk("at_cnt1", FRAME_CNT, 1);
        chk("at_gap_teston", TESTON, 0);
        repeat (8) @(negedge CLK);
        chk("at_run2_teston", TESTON, 1);
        man_te = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        man_te = 1'b0; ABORT = 1'b0;
        chk("at_cnt_held", FRAME_CNT, 1);
        chk("at_busy", BUSY, 0);
        chk("at_teston", TESTON, 0);
        // reset in the middle of a gap
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        man_te = 1'b1;
        @(negedge CLK);
        man_te = 1'b0;
        @(negedge CLK);
        chk("gap_busy", BUSY, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rg_teston", TESTON, 0);
        chk("rg_busy", BUSY, 0);
        chk("rg_cnt", FRAME_CNT, 0);
        chk("rg_done", DONE, 0);
        chk("rg_err", ERR, 0);
        repeat (10) @(negedge CLK);
        chk("rg_stays_idle", TESTON, 0);
        // narrow counter wraps in continuous mode
        gen_en = 1'b1; FRAME_NUM = 8'd0; GAP_CYCLES = 16'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            run_len(1'b1, n); chk("wrap_hi", n, 8);
            chk("wrap_cnt8", FRAME_CNT, f);
            chk("wrap_cnt2", frame_cnt2, f % 4);
            run_len(1'b0, n); chk("wrap_gap", n, 4);
        end
        chk("wrap_done2", done2, 0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("wrap_abort_busy2", busy2, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
